// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data RAM with 1-cycle registered reads, sticky address error flag
// Optional memory-mapped timer (mtime/mtimecmp/ctrl) enabled by `define DATA_MEMORY_TIMER_EN.
module data_memory #(
  parameter logic [31:0] DATA_BASE   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        addr_err,
  output logic        timer_irq
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
`ifdef DATA_MEMORY_TIMER_EN
  localparam bit          TIMER_EN  = 1'b1;
`else
  localparam bit          TIMER_EN  = 1'b0;
`endif

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      w_ram_off;
  logic [31:0]      w_mmio_off;
  logic             w_aligned;
  logic             w_ram_ok;
  logic             w_mmio_win;
  logic             w_reg_ok;
  logic             w_legal;
  logic             w_illegal;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_reg_rdata;
  logic [31:0]      w_rdata;

  // Unsigned subtraction wraps addresses below the base to huge offsets,
  // so a single upper-bound compare covers both ends of each window.
  assign w_ram_off  = dAddress - DATA_BASE;
  assign w_mmio_off = dAddress - MMIO_BASE;
  assign w_aligned  = (dAddress[1:0] == 2'b00);
  assign w_ram_ok   = w_aligned && (w_ram_off < RAM_BYTES);
  assign w_idx      = w_ram_off[IDX_W+1:2];
  assign w_mmio_win = (w_mmio_off < 32'h0000_1000);
  assign w_reg_ok   = TIMER_EN && w_mmio_win && w_aligned && (w_mmio_off < 32'd12);
  assign w_legal    = w_ram_ok || w_reg_ok;
  assign w_illegal  = (MemRead || MemWrite) && !w_legal;

  always_comb begin
    w_rdata = 32'h0;
    if (w_ram_ok) begin
      w_rdata = r_mem[w_idx];
    end else if (w_reg_ok) begin
      w_rdata = w_reg_rdata;
    end
  end

  // RAM has no reset; the reset branch only blocks a write on an edge where rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (MemWrite && w_ram_ok) begin
      r_mem[w_idx] <= dWriteData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dReadData <= 32'h0;
      addr_err  <= 1'b0;
    end else begin
      if (MemRead) begin
        dReadData <= w_rdata;
      end
      if (w_illegal) begin
        addr_err <= 1'b1;
      end
    end
  end

`ifdef DATA_MEMORY_TIMER_EN
  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
  logic        r_irq_en;
  logic        r_timer_irq;
  logic        w_reg_we;
  logic [1:0]  w_reg_sel;

  assign w_reg_we  = MemWrite && w_reg_ok;
  assign w_reg_sel = w_mmio_off[3:2];
  assign timer_irq = r_timer_irq;

  always_comb begin
    w_reg_rdata = 32'h0;
    case (w_reg_sel)
      2'd0:    w_reg_rdata = r_mtime;
      2'd1:    w_reg_rdata = r_mtimecmp;
      2'd2:    w_reg_rdata = {31'h0, r_irq_en};
      default: w_reg_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime     <= 32'h0;
      r_mtimecmp  <= 32'hFFFF_FFFF;
      r_irq_en    <= 1'b0;
      r_timer_irq <= 1'b0;
    end else begin
      if (w_reg_we && (w_reg_sel == 2'd0)) begin
        r_mtime <= dWriteData;
      end else begin
        r_mtime <= r_mtime + 32'd1;
      end
      if (w_reg_we && (w_reg_sel == 2'd1)) begin
        r_mtimecmp <= dWriteData;
      end
      if (w_reg_we && (w_reg_sel == 2'd2)) begin
        r_irq_en <= dWriteData[0];
      end
      r_timer_irq <= r_irq_en && (r_mtime >= r_mtimecmp);
    end
  end
`else
  assign w_reg_rdata = 32'h0;
  assign timer_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        addr_err;
  logic        timer_irq;

  int tests;
  int fails;

  data_memory dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .dAddress   (dAddress),
    .dWriteData (dWriteData),
    .dReadData  (dReadData),
    .addr_err   (addr_err),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead    = rd;
    MemWrite   = wr;
    dAddress   = a;
    dWriteData = d;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(2);
    tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want %h", dReadData, 32'h0); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", addr_err); end
    tests++; if (timer_irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_write_read;
    access(1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10010004, 32'h0);
    tests++; if (dReadData !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd got %h want %h", dReadData, 32'hDEADBEEF); end
    dAddress = 32'h10010000;
    idle(2);
    tests++; if (dReadData !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold got %h want %h", dReadData, 32'hDEADBEEF); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL wr_rd_err got %b want 0", addr_err); end
  endtask

  task automatic test_read_first;
    access(1'b0, 1'b1, 32'h10010008, 32'h11111111);
    access(1'b1, 1'b1, 32'h10010008, 32'h22222222);
    tests++; if (dReadData !== 32'h11111111) begin fails++; $display("FAIL rmw_old got %h want %h", dReadData, 32'h11111111); end
    access(1'b1, 1'b0, 32'h10010008, 32'h0);
    tests++; if (dReadData !== 32'h22222222) begin fails++; $display("FAIL rmw_new got %h want %h", dReadData, 32'h22222222); end
  endtask

  task automatic test_boundary;
    access(1'b0, 1'b1, 32'h10010000, 32'h12345678);
    access(1'b0, 1'b1, 32'h10010FFC, 32'hA5A5C3C3);
    access(1'b1, 1'b0, 32'h10010FFC, 32'h0);
    tests++; if (dReadData !== 32'hA5A5C3C3) begin fails++; $display("FAIL last_word got %h want %h", dReadData, 32'hA5A5C3C3); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL last_word_err got %b want 0", addr_err); end
    access(1'b1, 1'b0, 32'h10011000, 32'h0);
    tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL past_end got %h want %h", dReadData, 32'h0); end
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL past_end_err got %b want 1", addr_err); end
    access(1'b0, 1'b1, 32'h10010002, 32'h99999999);
    access(1'b1, 1'b0, 32'h10010000, 32'h0);
    tests++; if (dReadData !== 32'h12345678) begin fails++; $display("FAIL misalign_wr got %h want %h", dReadData, 32'h12345678); end
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL misalign_err got %b want 1", addr_err); end
    access(1'b1, 1'b0, 32'h1000FFFC, 32'h0);
    tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL below_base got %h want %h", dReadData, 32'h0); end
  endtask

  task automatic test_reset_midrun;
    access(1'b1, 1'b0, 32'h10010004, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL mid_rst_rdata got %h want %h", dReadData, 32'h0); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL mid_rst_err got %b want 0", addr_err); end
    tests++; if (timer_irq !== 1'b0) begin fails++; $display("FAIL mid_rst_irq got %b want 0", timer_irq); end
    MemWrite   = 1'b1;
    dAddress   = 32'h10010004;
    dWriteData = 32'h0BAD0BAD;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    rst      = 1'b1;
    access(1'b1, 1'b0, 32'h10010004, 32'h0);
    tests++; if (dReadData !== 32'hDEADBEEF) begin fails++; $display("FAIL rst_abandon_wr got %h want %h", dReadData, 32'hDEADBEEF); end
  endtask

`ifdef DATA_MEMORY_TIMER_EN
  task automatic test_timer;
    access(1'b0, 1'b1, 32'hFFFF0004, 32'd10);
    access(1'b0, 1'b1, 32'hFFFF0000, 32'd0);
    access(1'b0, 1'b1, 32'hFFFF0008, 32'd1);
    idle(9);
    tests++; if (timer_irq !== 1'b0) begin fails++; $display("FAIL irq_early got %b want 0", timer_irq); end
    idle(1);
    tests++; if (timer_irq !== 1'b1) begin fails++; $display("FAIL irq_rise got %b want 1", timer_irq); end
    access(1'b1, 1'b0, 32'hFFFF0008, 32'h0);
    tests++; if (dReadData !== 32'h1) begin fails++; $display("FAIL ctrl_rd got %h want %h", dReadData, 32'h1); end
    access(1'b0, 1'b1, 32'hFFFF0000, 32'hFFFFFFFE);
    idle(1);
    access(1'b1, 1'b0, 32'hFFFF0000, 32'h0);
    tests++; if (dReadData !== 32'hFFFFFFFF) begin fails++; $display("FAIL mtime_max got %h want %h", dReadData, 32'hFFFFFFFF); end
    access(1'b1, 1'b0, 32'hFFFF0000, 32'h0);
    tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL mtime_wrap got %h want %h", dReadData, 32'h0); end
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL timer_err got %b want 0", addr_err); end
    access(1'b1, 1'b0, 32'hFFFF000C, 32'h0);
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL mmio_hole_err got %b want 1", addr_err); end
  endtask
`else
  task automatic test_no_timer;
    access(1'b1, 1'b0, 32'h10010004, 32'h0);
    access(1'b0, 1'b1, 32'hFFFF0004, 32'h00000005);
    access(1'b1, 1'b0, 32'hFFFF0004, 32'h0);
    tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL mmio_rd got %h want %h", dReadData, 32'h0); end
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL mmio_err got %b want 1", addr_err); end
    idle(20);
    tests++; if (timer_irq !== 1'b0) begin fails++; $display("FAIL mmio_irq got %b want 0", timer_irq); end
  endtask
`endif

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    dAddress   = 32'h0;
    dWriteData = 32'h0;
    test_reset;
    test_write_read;
    test_read_first;
    test_boundary;
    test_reset_midrun;
`ifdef DATA_MEMORY_TIMER_EN
    test_timer;
`else
    test_no_timer;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
